// File: rtl/memory_stage_pkg.sv
// memory_stage_pkg: shared types for the memory stage.
//   control_type   - pipeline control bits consumed by the MEM stage
//   mem_size_type  - funct3 access size/sign encodings
//   mem_state_type - data-memory handshake FSM states
//   is_misaligned  - true when a half/word address is not naturally aligned
package memory_stage_pkg;

   typedef struct packed {
      logic MemRead;
      logic MemWrite;
      logic RegWrite;
      logic MemtoReg;
   } control_type;

   typedef enum logic [2:0] {
      MemB  = 3'b000,
      MemH  = 3'b001,
      MemW  = 3'b010,
      MemBu = 3'b100,
      MemHu = 3'b101
   } mem_size_type;

   typedef enum logic {
      StIdle = 1'b0,
      StWait = 1'b1
   } mem_state_type;

   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
      logic mis;
      mis = 1'b0;
      case (funct3[1:0])
         2'b01:   mis = addr_lo[0];
         2'b10:   mis = (addr_lo != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/memory_stage_load_store_align.sv
// load_store_align: combinational byte-lane logic for the memory stage.
//   funct3_i      - access size/sign
//   addr_lo_i     - low two bits of the effective address
//   is_load_i     - access is a load (loads enable all four lanes)
//   store_data_i  - raw store data (rs2)
//   rdata_i       - load word from data memory
//   be_o          - byte enables
//   wdata_o       - lane-replicated store data
//   load_value_o  - extracted and sign/zero-extended load result
// Half and word lane offsets are forced to natural alignment.
module load_store_align
   import memory_stage_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  addr_lo_i,
   input  logic        is_load_i,
   input  logic [31:0] store_data_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] load_value_o
);

   logic [1:0]  off;
   logic [31:0] rshift;

   always_comb begin
      off          = 2'b00;
      rshift       = 32'h0;
      be_o         = 4'hF;
      wdata_o      = store_data_i;
      load_value_o = rdata_i;

      case (mem_size_type'(funct3_i))
         MemB, MemBu: off = addr_lo_i;
         MemH, MemHu: off = {addr_lo_i[1], 1'b0};
         default:     off = 2'b00;
      endcase

      // Selected lane moved down to bit 0.
      rshift = rdata_i >> {off, 3'b000};

      case (mem_size_type'(funct3_i))
         MemB: begin
            be_o         = 4'b0001 << off;
            wdata_o      = {4{store_data_i[7:0]}};
            load_value_o = {{24{rshift[7]}}, rshift[7:0]};
         end
         MemBu: begin
            be_o         = 4'b0001 << off;
            wdata_o      = {4{store_data_i[7:0]}};
            load_value_o = {24'h0, rshift[7:0]};
         end
         MemH: begin
            be_o         = 4'b0011 << off;
            wdata_o      = {2{store_data_i[15:0]}};
            load_value_o = {{16{rshift[15]}}, rshift[15:0]};
         end
         MemHu: begin
            be_o         = 4'b0011 << off;
            wdata_o      = {2{store_data_i[15:0]}};
            load_value_o = {16'h0, rshift[15:0]};
         end
         default: begin
            be_o         = 4'hF;
            wdata_o      = store_data_i;
            load_value_o = rdata_i;
         end
      endcase

      if (is_load_i) begin
         be_o = 4'hF;
      end
   end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: EX/MEM consumer driving a req/ack data-memory port and the MEM/WB register.
//   clk, rst (sync, active high)
//   valid_in, control_in, alu_data, memory_data, rd_in, funct3 - EX/MEM slot
//   dmem_req/we/addr/wdata/be, dmem_ack/rdata                   - data-memory port
//   stall                                                        - freeze upstream stages
//   ex_mem_rd, ex_mem_RegWrite, forward_ex_mem                   - EX/MEM forwarding source
//   control_out, rd_out/mem_wb_rd, mem_wb_RegWrite,
//   wb_data/forward_mem_wb, valid_out                            - MEM/WB slot
// Optional macro MISALIGN_TRAP_EN adds output 'misaligned': misaligned half/word accesses
// are not issued and retire with register write suppressed.
module memory_stage
   import memory_stage_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_in,
   input  control_type       control_in,
   input  logic [31:0]       alu_data,
   input  logic [31:0]       memory_data,
   input  logic [4:0]        rd_in,
   input  logic [2:0]        funct3,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   output logic [3:0]        dmem_be,
   input  logic              dmem_ack,
   input  logic [31:0]       dmem_rdata,
   output logic              stall,
   output logic [4:0]        ex_mem_rd,
   output logic              ex_mem_RegWrite,
   output logic [31:0]       forward_ex_mem,
   output control_type       control_out,
   output logic [4:0]        rd_out,
   output logic [4:0]        mem_wb_rd,
   output logic              mem_wb_RegWrite,
   output logic [31:0]       wb_data,
   output logic [31:0]       forward_mem_wb,
   output logic              valid_out
`ifdef MISALIGN_TRAP_EN
   ,
   output logic              misaligned
`endif
);

   mem_state_type state_q, state_d;
   logic          valid_q, valid_d;
   control_type   control_q, control_d;
   logic [4:0]    rd_q, rd_d;
   logic [31:0]   wb_data_q, wb_data_d;
   logic          mis_q, mis_d;

   logic          memop;
   logic          mis;
   logic          issue;
   logic [3:0]    be;
   logic [31:0]   wdata;
   logic [31:0]   load_value;

   assign memop = valid_in & (control_in.MemRead | control_in.MemWrite);

`ifdef MISALIGN_TRAP_EN
   assign mis = memop & is_misaligned(funct3, alu_data[1:0]);
`else
   assign mis = 1'b0;
`endif

   assign issue = memop & ~mis;

   load_store_align u_align (
      .funct3_i     (funct3),
      .addr_lo_i    (alu_data[1:0]),
      .is_load_i    (control_in.MemRead),
      .store_data_i (memory_data),
      .rdata_i      (dmem_rdata),
      .be_o         (be),
      .wdata_o      (wdata),
      .load_value_o (load_value)
   );

   // Mealy request so a zero-wait-state memory completes in the issue cycle.
   assign dmem_req   = ((state_q == StIdle) & issue) | (state_q == StWait);
   assign stall      = dmem_req & ~dmem_ack;
   // MemRead+MemWrite together is treated as a load.
   assign dmem_we    = dmem_req & control_in.MemWrite & ~control_in.MemRead;
   assign dmem_addr  = {alu_data[ADDR_W-1:2], 2'b00};
   assign dmem_be    = be;
   assign dmem_wdata = wdata;

   assign ex_mem_rd       = rd_in;
   // Load data is not available yet; load-use is resolved by the hazard unit.
   assign ex_mem_RegWrite = valid_in & control_in.RegWrite & ~control_in.MemRead;
   assign forward_ex_mem  = alu_data;

   always_comb begin
      state_d   = state_q;
      valid_d   = valid_q;
      control_d = control_q;
      rd_d      = rd_q;
      wb_data_d = wb_data_q;
      mis_d     = mis_q;

      case (state_q)
         StIdle:  if (dmem_req && !dmem_ack) state_d = StWait;
         StWait:  if (dmem_ack) state_d = StIdle;
         default: state_d = StIdle;
      endcase

      if (stall) begin
         // Bubble into MEM/WB; other fields hold.
         valid_d = 1'b0;
         mis_d   = 1'b0;
      end else begin
         valid_d   = valid_in;
         control_d = control_in;
         rd_d      = rd_in;
         wb_data_d = control_in.MemtoReg ? load_value : alu_data;
         mis_d     = mis;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         valid_q   <= 1'b0;
         control_q <= '0;
         rd_q      <= 5'd0;
         wb_data_q <= 32'h0;
         mis_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         valid_q   <= valid_d;
         control_q <= control_d;
         rd_q      <= rd_d;
         wb_data_q <= wb_data_d;
         mis_q     <= mis_d;
      end
   end

   assign valid_out       = valid_q;
   assign control_out     = control_q;
   assign rd_out          = rd_q;
   assign mem_wb_rd       = rd_q;
   assign wb_data         = wb_data_q;
   assign forward_mem_wb  = wb_data_q;
   assign mem_wb_RegWrite = valid_q & control_q.RegWrite & ~mis_q;

`ifdef MISALIGN_TRAP_EN
   assign misaligned = mis_q;
`endif

endmodule
